instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage directly upstream of the instruction decoder. Keeps the PC and issues
//   word reads to instruction memory over a valid/ready request plus in-order response.
// - Buffers returned words with their PC and presents them to decode on valid/ready.
// - Redirects (branch, or a write to R15) flush the buffer and discard stale responses.
// PARAMETERS
// - ADDR_W    32  PC / memory address width
// - DEPTH     2   max (outstanding requests + buffered instructions); power of 2, >=2
// - RESET_PC  0   PC fetched first after reset
// PORTS
// - clk             in   1       single clock, rising edge
// - reset_n         in   1       asynchronous, active-low reset
// - imem_req_valid  out  1       fetch request valid
// - imem_req_ready  in   1       memory accepts request
// - imem_req_addr   out  ADDR_W  word-aligned fetch address (= pc)
// - imem_rsp_valid  in   1       one response per accepted request, in order
// - imem_rsp_data   in   32      instruction word
// - redirect_valid  in   1       branch/PC-write taken this cycle (from PCS path)
// - redirect_pc     in   ADDR_W  target; bits[1:0] ignored (forced 0)
// - instr_valid     out  1       instruction available to decode
// - instr_ready     in   1       decode consumes instruction
// - instr           out  32      instruction word (Op = [27:26], Funct = [25:20], Rd = [15:12])
// - instr_pc        out  ADDR_W  address of instr
// - instr_pc_plus8  out  ADDR_W  instr_pc + 8 (architectural R15 read value)
// BEHAVIOUR
// - Reset state: pc = rsp_pc = RESET_PC, FIFO empty, outstanding = 0, drop_cnt = 0, state = WAIT.
// - Reset outputs: imem_req_valid = 0, instr_valid = 0, imem_req_addr = RESET_PC,
//   instr = 0, instr_pc = 0, instr_pc_plus8 = 8.
// - State machine (3 states):
//   - WAIT: one cycle after reset release, then RUN. This keeps req_valid low on the release edge.
//   - RUN: normal fetch.
//   - FLUSH: discards stale responses until drop_cnt == 0, then returns to RUN.
// - Issue: imem_req_valid = (state == RUN) & !redirect_valid & (outstanding + count < DEPTH).
//   - count is FIFO occupancy, sampled before this cycle's pop (conservative).
//   - The request handshake sets pc <= pc + 4 and outstanding += 1.
//   - imem_req_valid and imem_req_addr stay stable while waiting for ready.
// - Response in RUN with no redirect: push {data, rsp_pc}, set rsp_pc += 4, outstanding -= 1.
//   The credit rule guarantees the FIFO never overflows. A push while full is an assertion failure.
// - Decode side: instr_valid = !empty, outputs taken from the FIFO head, pop on valid & ready.
//   - Fall-through latency: response cycle N -> instr_valid in cycle N+1.
//   - Push and pop in the same cycle are both allowed.
// - Redirect (any state) takes priority over push, pop and issue:
//   - pc <= rsp_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, FIFO cleared next cycle.
//   - drop_cnt <= outstanding - rsp_valid. A same-cycle response is already stale.
//   - Next state is FLUSH if that value is > 0, else RUN.
//   - A redirect during FLUSH recomputes drop_cnt the same way. All older requests are stale.
// - FLUSH: each rsp_valid decrements drop_cnt and outstanding; data is discarded; no issue.
// - Widths: pc arithmetic wraps modulo 2^ADDR_W. outstanding and drop_cnt are $clog2(DEPTH)+1 bits.
// - A reset mid-operation drops everything and returns to WAIT.
//   Memory must also drop responses owed to requests from before the reset.
// STRUCTURE
// - fetch_pkg: fetch_state_t enum {WAIT, RUN, FLUSH}; localparams PC_STEP = 4, R15_OFFSET = 8.
// - Sub-module fetch_fifo: DEPTH x (32 + ADDR_W) sync FIFO.
//   - Ports: push, pop, clear, full, empty, count.
//   - Async active-low reset; clear has priority over push.
// - Top level holds pc, rsp_pc, outstanding, drop_cnt and the FSM.
// TESTING
// - Reset release, memory always ready, 1-cycle response, decode always ready:
//   -> req addrs 0,4,8; instr_valid first in cycle 3 after release; instr_pc 0,4,8; pc_plus8 8,12,16.
// - Decode stalls (instr_ready = 0) for 10 cycles:
//   -> at most DEPTH requests outstanding + buffered, no push while full, no word lost.
//   -> on resume, order 0,4,... is preserved.
// - Redirect to 0x100 with 2 outstanding and a same-cycle response:
//   -> drop_cnt = 1, state FLUSH; next response discarded.
//   -> next req addr 0x100; first delivered instr_pc = 0x100.
// - Redirect_pc = 0x103 while FIFO full and decode popping:
//   -> FIFO empty next cycle, instr_valid = 0, next fetch addr 0x100.
// - Back-to-back redirects to 0x200 then 0x300 during FLUSH:
//   -> only 0x300-stream instructions are delivered; outstanding returns to 0 before the first 0x300 issue.
// - pc = 0xFFFF_FFFC fetch, then reset_n pulsed low mid-flush:
//   -> next fetch addr wraps to 0x0; after reset, outputs take reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {WAIT, RUN, FLUSH} fetch_state_t;

  localparam int PC_STEP    = 4;
  localparam int R15_OFFSET = 8;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs for the decoder.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage is zeroed on reset so the head reads as all-zero before any fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads under a credit limit and
// buffers returned words for decode; redirects flush and drop stale responses.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_plus8
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t         state;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    rsp_pc;
  logic [ADDR_W-1:0]    target;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        drop_next;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 req_fire;
  logic                 credit_ok;
  logic [32+ADDR_W-1:0] head;

  assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign drop_next = outstanding - CW'(imem_rsp_valid);

  // Occupancy is taken before any pop this cycle, so a slot is only reused a cycle later.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign imem_req_valid = (state == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = (state == RUN) && !redirect_valid && imem_rsp_valid;
  assign pop  = !empty && instr_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32 + ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .clear  (redirect_valid),
    .wdata  ({imem_rsp_data, rsp_pc}),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign instr_valid    = !empty;
  assign instr          = head[32+ADDR_W-1:ADDR_W];
  assign instr_pc       = head[ADDR_W-1:0];
  assign instr_pc_plus8 = instr_pc + ADDR_W'(R15_OFFSET);

  // Redirect wins over everything; any response arriving with it is already stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      pc          <= target;
      rsp_pc      <= target;
      outstanding <= drop_next;
      drop_cnt    <= drop_next;
      state       <= (drop_next != '0) ? FLUSH : RUN;
    end else begin
      case (state)
        WAIT: state <= RUN;
        RUN: begin
          if (req_fire) pc <= pc + ADDR_W'(PC_STEP);
          if (imem_rsp_valid) rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
          outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        end
        FLUSH: begin
          if (imem_rsp_valid) begin
            outstanding <= outstanding - CW'(1);
            drop_cnt    <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state <= RUN;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a stream-level model of fetch order.
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus8;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus8(instr_pc_plus8)
  );

  int checks = 0;
  int errors = 0;

  // Memory image: every address holds a distinct word, so a stale word shows up as a data error.
  logic [31:0] q_addr [$];
  int          q_epoch [$];
  int          epoch = 0;
  logic [31:0] exp_req;
  logic [31:0] exp_del;
  bit          prev_wait;
  logic [31:0] prev_addr;
  bit          o_req_valid;
  bit          o_instr_valid;
  logic [31:0] o_req_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_valid", imem_req_valid, 0);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_pc_plus8", instr_pc_plus8, 8);
  endtask

  // Holds reset for a few cycles, then releases it on a falling edge.
  task automatic applyReset(input int cycles);
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    #1;
    checkResetOutputs();
    repeat (cycles) @(negedge clk);
    q_addr.delete();
    q_epoch.delete();
    epoch++;
    exp_req   = RESET_PC;
    exp_del   = RESET_PC;
    prev_wait = 1'b0;
    reset_n   = 1'b1;
    #1;
    checkOutput("wait_no_req", imem_req_valid, 0);
  endtask

  // One cycle: drive inputs, sample outputs, advance the reference model.
  task automatic applyStimulus(input bit redir, input logic [31:0] tgt,
                               input int rsp_pct, input int rdy_pct, input int dec_pct);
    bit rsp;
    bit any_stale;
    @(negedge clk);
    rsp            = (q_addr.size() > 0) && ($urandom_range(99) < rsp_pct);
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(q_addr[0]) : 32'hDEAD_BEEF;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready    = ($urandom_range(99) < dec_pct);
    #1;
    o_req_valid   = imem_req_valid;
    o_req_addr    = imem_req_addr;
    o_instr_valid = instr_valid;
    if (redir) begin
      checkOutput("req_during_redir", imem_req_valid, 0);
      exp_req   = {tgt[31:2], 2'b00};
      exp_del   = {tgt[31:2], 2'b00};
      epoch++;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        checkOutput("req_hold_valid", imem_req_valid, 1);
        checkOutput("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (instr_valid && instr_ready) begin
        checkOutput("instr_pc", instr_pc, exp_del);
        checkOutput("instr", instr, memf(exp_del));
        checkOutput("pc_plus8", instr_pc_plus8, exp_del + 32'd8);
        exp_del += 32'd4;
      end
      if (imem_req_valid) begin
        checkOutput("req_addr", imem_req_addr, exp_req);
        if (imem_req_ready) begin
          any_stale = 1'b0;
          foreach (q_epoch[i]) if (q_epoch[i] != epoch) any_stale = 1'b1;
          checkOutput("stale_at_issue", any_stale, 0);
          q_addr.push_back(imem_req_addr);
          q_epoch.push_back(epoch);
          exp_req += 32'd4;
        end
      end
      prev_wait = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
    end
    if (rsp) begin
      void'(q_addr.pop_front());
      void'(q_epoch.pop_front());
    end
    checkOutput("credit_limit", q_addr.size() <= DEPTH, 1);
  endtask

  // Runs with responses withheld until two requests are in flight.
  task automatic fillOutstanding();
    for (int i = 0; i < 20 && q_addr.size() < 2; i++) applyStimulus(0, 0, 0, 100, 100);
    checkOutput("fill_outstanding", q_addr.size(), 2);
  endtask

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    // Startup: ideal memory and decoder.
    applyReset(3);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 0, 100, 100, 100);
      checkOutput("first_valid", o_instr_valid, (c == 3));
    end
    repeat (6) applyStimulus(0, 0, 100, 100, 100);

    // Decode stall: credits run out, then the stream resumes in order.
    repeat (10) applyStimulus(0, 0, 100, 100, 0);
    checkOutput("stall_no_req", o_req_valid, 0);
    checkOutput("stall_no_outst", q_addr.size(), 0);
    repeat (10) applyStimulus(0, 0, 100, 100, 100);

    // Redirect to 0x100 with two in flight and a same-cycle response.
    fillOutstanding();
    applyStimulus(1, 32'h100, 100, 100, 100);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("flush_no_req", o_req_valid, 0);
    applyStimulus(0, 0, 100, 100, 100);
    checkOutput("flush_drop_no_req", o_req_valid, 0);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("redir_req_valid", o_req_valid, 1);
    checkOutput("redir_req_addr", o_req_addr, 32'h100);
    repeat (10) applyStimulus(0, 0, 100, 100, 100);

    // Unaligned redirect while the buffer is full and decode is popping.
    repeat (8) applyStimulus(0, 0, 100, 100, 0);
    checkOutput("full_instr_valid", o_instr_valid, 1);
    checkOutput("full_no_req", o_req_valid, 0);
    applyStimulus(1, 32'h103, 0, 100, 100);
    applyStimulus(0, 0, 0, 0, 100);
    checkOutput("clr_instr_valid", o_instr_valid, 0);
    checkOutput("clr_req_addr", o_req_addr, 32'h100);
    repeat (10) applyStimulus(0, 0, 100, 100, 100);

    // Back-to-back redirects while flushing.
    fillOutstanding();
    applyStimulus(1, 32'h200, 0, 100, 100);
    applyStimulus(1, 32'h300, 0, 100, 100);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("b2b_no_req", o_req_valid, 0);
    repeat (30) applyStimulus(0, 0, 50, 70, 70);

    // Address wrap, then reset in the middle of a flush.
    applyStimulus(1, 32'hFFFF_FFFC, 100, 100, 100);
    for (int i = 0; i < 20 && !o_req_valid; i++) applyStimulus(0, 0, 100, 100, 100);
    checkOutput("wrap_first_addr", o_req_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("wrap_next_addr", o_req_addr, 32'h0);
    applyStimulus(1, 32'h40, 0, 100, 100);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("pre_reset_flush", o_req_valid, 0);
    applyReset(2);
    applyStimulus(0, 0, 0, 100, 100);
    checkOutput("restart_valid", o_req_valid, 1);
    checkOutput("restart_addr", o_req_addr, RESET_PC);
    repeat (10) applyStimulus(0, 0, 100, 100, 100);

    // Random traffic with occasional redirects to arbitrary targets.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(99) < 3), $urandom, 60, 70, 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
